// File: rtl/gpr_write_arbiter_pkg.sv
// gpr_write_arbiter_pkg: shared register-file types and the write-request record
package gpr_write_arbiter_pkg;
  typedef logic [31:0] Data;
  typedef logic [4:0]  GPRAddr;
  typedef struct packed {
    GPRAddr addr;
    Data    data;
  } GprWrReq;
endpackage

// File: rtl/gpr_wr_fifo.sv
// gpr_wr_fifo: synchronous FIFO of register write requests exposing every slot for hazard compares
module gpr_wr_fifo
  import gpr_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  push,
  input  logic                  pop,
  input  GprWrReq               din,
  output logic                  full,
  output logic                  empty,
  output GprWrReq               head,
  output GprWrReq [DEPTH-1:0]   entries,
  output logic    [DEPTH-1:0]   valid
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  GprWrReq [DEPTH-1:0] mem;
  // pointer and occupancy bookkeeping; reset discards every queued entry
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // storage needs no reset since slot validity comes from the pointers
  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr] <= din;
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [AW-1:0] off;
    assign off      = AW'(i) - rd_ptr;
    assign valid[i] = {1'b0, off} < count;
  end
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  assign entries = mem;
endmodule

// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter: shares the register-file write port between in-order write-back and long-latency units
module gpr_write_arbiter
  import gpr_write_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic   i_clock,
  input  logic   i_reset,
  input  logic   i_aValid,
  input  logic   i_aWrEnable,
  input  GPRAddr i_aAddr,
  input  Data    i_aData,
  input  logic   i_bValid,
  input  GPRAddr i_bAddr,
  input  Data    i_bData,
  output logic   o_bReady,
  input  GPRAddr i_rdAddr1,
  input  GPRAddr i_rdAddr2,
  output logic   o_hazard,
  output logic   o_stallReq,
  output logic   o_wr,
  output GPRAddr o_wrAddr,
  output Data    o_wrData,
  output logic   o_busy
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic a_wr, push, pop, full, empty, head_wr;
  logic [WW-1:0] wait_cnt;
  GprWrReq head;
  GprWrReq [DEPTH-1:0] entries;
  logic [DEPTH-1:0] valid;
  gpr_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .push    (push),
    .pop     (pop),
    .din     ('{addr: i_bAddr, data: i_bData}),
    .full    (full),
    .empty   (empty),
    .head    (head),
    .entries (entries),
    .valid   (valid)
  );
  assign a_wr     = i_aValid & i_aWrEnable & (i_aAddr != '0);
  assign o_bReady = !full;
  assign push     = i_bValid & !full;
  assign pop      = !empty & !a_wr;
  assign head_wr  = pop & (head.addr != '0);
  assign o_busy   = !empty;
  assign o_stallReq = wait_cnt == WW'(MAX_WAIT);
  // port A wins the write port; a drained x0 head is dropped silently
  always_comb begin
    o_wr     = a_wr | head_wr;
    o_wrAddr = a_wr ? i_aAddr : head_wr ? head.addr : '0;
    o_wrData = a_wr ? i_aData : head_wr ? head.data : '0;
  end
  // starvation counter tracks consecutive cycles the head loses to port A
  always_ff @(posedge i_clock) begin
    if (!i_reset || empty || pop) wait_cnt <= '0;
    else if (!o_stallReq) wait_cnt <= wait_cnt + 1'b1;
  end
  // decode must not read a register whose result is still queued
  always_comb begin
    o_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && entries[i].addr != '0 &&
          (entries[i].addr == i_rdAddr1 || entries[i].addr == i_rdAddr2))
        o_hazard = 1'b1;
  end
endmodule

// File: tb/tb_gpr_write_arbiter.sv
// tb_gpr_write_arbiter: directed self-checking bench for the register write-port arbiter
module tb_gpr_write_arbiter;
  logic        i_clock = 0;
  logic        i_reset;
  logic        i_aValid, i_aWrEnable, i_bValid;
  logic [4:0]  i_aAddr, i_bAddr, i_rdAddr1, i_rdAddr2;
  logic [31:0] i_aData, i_bData;
  logic        o_bReady, o_hazard, o_stallReq, o_wr, o_busy;
  logic [4:0]  o_wrAddr;
  logic [31:0] o_wrData;
  int checks = 0, errors = 0;

  gpr_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_aValid(i_aValid), .i_aWrEnable(i_aWrEnable), .i_aAddr(i_aAddr), .i_aData(i_aData),
    .i_bValid(i_bValid), .i_bAddr(i_bAddr), .i_bData(i_bData), .o_bReady(o_bReady),
    .i_rdAddr1(i_rdAddr1), .i_rdAddr2(i_rdAddr2), .o_hazard(o_hazard), .o_stallReq(o_stallReq),
    .o_wr(o_wr), .o_wrAddr(o_wrAddr), .o_wrData(o_wrData), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    i_aValid = av; i_aWrEnable = av; i_aAddr = aa; i_aData = ad;
    i_bValid = bv; i_bAddr = ba; i_bData = bd;
  endtask

  task automatic test_reset;
    i_reset = 0; i_rdAddr1 = 0; i_rdAddr2 = 0;
    drive(1, 5, 32'h11, 0, 0, 0);
    #1;
    checks++;
    if ({o_wr, o_wrAddr, o_wrData} !== {1'b1, 5'd5, 32'h11}) begin
      errors++; $display("FAIL reset_a_write: got %b/%0d/%h want 1/5/11", o_wr, o_wrAddr, o_wrData);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #4;
    checks++;
    if ({o_busy, o_bReady, o_hazard, o_stallReq, o_wr} !== 5'b01000) begin
      errors++; $display("FAIL reset_state: busy/ready/haz/stall/wr got %b want 01000",
                         {o_busy, o_bReady, o_hazard, o_stallReq, o_wr});
    end
    i_reset = 1;
  endtask

  task automatic test_single_push;
    tick();
    drive(0, 0, 0, 1, 7, 32'hAB); i_rdAddr1 = 7;
    #4;
    checks++;
    if ({o_bReady, o_wr, o_hazard} !== 3'b100) begin
      errors++; $display("FAIL single_pre: ready/wr/haz got %b want 100", {o_bReady, o_wr, o_hazard});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #4;
    checks++;
    if ({o_hazard, o_busy} !== 2'b11) begin
      errors++; $display("FAIL single_hazard: haz/busy got %b want 11", {o_hazard, o_busy});
    end
    checks++;
    if ({o_wr, o_wrAddr, o_wrData} !== {1'b1, 5'd7, 32'hAB}) begin
      errors++; $display("FAIL single_write: got %b/%0d/%h want 1/7/ab", o_wr, o_wrAddr, o_wrData);
    end
    tick();
    #4;
    checks++;
    if ({o_busy, o_hazard, o_wr} !== 3'b000) begin
      errors++; $display("FAIL single_drained: busy/haz/wr got %b want 000", {o_busy, o_hazard, o_wr});
    end
    i_rdAddr1 = 0;
  endtask

  task automatic test_starvation;
    tick(); drive(1, 1, 32'h1, 1, 3, 32'h33);
    tick(); drive(1, 1, 32'h2, 1, 4, 32'h44);
    #4;
    checks++;
    if (o_bReady !== 1'b1) begin errors++; $display("FAIL starve_ready1: got %b want 1", o_bReady); end
    tick(); drive(1, 1, 32'h3, 1, 5, 32'h55);
    #4;
    checks++;
    if (o_bReady !== 1'b0) begin errors++; $display("FAIL starve_full: ready got %b want 0", o_bReady); end
    tick(); drive(1, 1, 32'h4, 0, 0, 0);
    tick();
    #4;
    checks++;
    if (o_stallReq !== 1'b0) begin errors++; $display("FAIL starve_early: stall got %b want 0", o_stallReq); end
    tick(); drive(1, 2, 32'h5, 0, 0, 0);
    #4;
    checks++;
    if (o_stallReq !== 1'b1) begin errors++; $display("FAIL starve_stall: stall got %b want 1", o_stallReq); end
    checks++;
    if ({o_wr, o_wrAddr, o_wrData} !== {1'b1, 5'd2, 32'h5}) begin
      errors++; $display("FAIL starve_a_wins: got %b/%0d/%h want 1/2/5", o_wr, o_wrAddr, o_wrData);
    end
    tick(); drive(0, 0, 0, 0, 0, 0);
    #4;
    checks++;
    if ({o_wr, o_wrAddr, o_wrData, o_stallReq} !== {1'b1, 5'd3, 32'h33, 1'b1}) begin
      errors++; $display("FAIL starve_drain1: got %b/%0d/%h stall %b want 1/3/33 stall 1",
                         o_wr, o_wrAddr, o_wrData, o_stallReq);
    end
    tick();
    #4;
    checks++;
    if ({o_wr, o_wrAddr, o_wrData, o_stallReq} !== {1'b1, 5'd4, 32'h44, 1'b0}) begin
      errors++; $display("FAIL starve_drain2: got %b/%0d/%h stall %b want 1/4/44 stall 0",
                         o_wr, o_wrAddr, o_wrData, o_stallReq);
    end
    tick();
    #4;
    checks++;
    if ({o_busy, o_wr} !== 2'b00) begin errors++; $display("FAIL starve_empty: busy/wr got %b want 00", {o_busy, o_wr}); end
  endtask

  task automatic test_x0;
    tick(); drive(1, 0, 32'h99, 1, 0, 32'hFF);
    #4;
    checks++;
    if (o_wr !== 1'b0) begin errors++; $display("FAIL x0_a: wr got %b want 0", o_wr); end
    tick(); drive(0, 0, 0, 0, 0, 0);
    #4;
    checks++;
    if ({o_busy, o_wr, o_hazard} !== 3'b100) begin
      errors++; $display("FAIL x0_head: busy/wr/haz got %b want 100", {o_busy, o_wr, o_hazard});
    end
    tick();
    #4;
    checks++;
    if ({o_busy, o_wr} !== 2'b00) begin errors++; $display("FAIL x0_empty: busy/wr got %b want 00", {o_busy, o_wr}); end
  endtask

  task automatic test_full_pop;
    tick(); drive(1, 1, 32'h1, 1, 8, 32'h80);
    tick(); drive(1, 1, 32'h2, 1, 9, 32'h90);
    tick(); drive(0, 0, 0, 1, 10, 32'hA0);
    #4;
    checks++;
    if ({o_bReady, o_wr, o_wrAddr} !== {1'b0, 1'b1, 5'd8}) begin
      errors++; $display("FAIL fullpop_pop: ready %b wr %b addr %0d want 0 1 8", o_bReady, o_wr, o_wrAddr);
    end
    tick(); drive(0, 0, 0, 0, 0, 0); i_rdAddr1 = 10; i_rdAddr2 = 9;
    #4;
    checks++;
    if ({o_bReady, o_busy, o_wr, o_wrAddr, o_wrData} !== {1'b1, 1'b1, 1'b1, 5'd9, 32'h90}) begin
      errors++; $display("FAIL fullpop_next: ready %b busy %b wr %b/%0d/%h want 1 1 1/9/90",
                         o_bReady, o_busy, o_wr, o_wrAddr, o_wrData);
    end
    checks++;
    if (o_hazard !== 1'b1) begin errors++; $display("FAIL fullpop_haz9: got %b want 1", o_hazard); end
    i_rdAddr2 = 0;
    #1;
    checks++;
    if (o_hazard !== 1'b0) begin errors++; $display("FAIL fullpop_haz10: got %b want 0", o_hazard); end
    tick();
    #4;
    checks++;
    if ({o_busy, o_wr} !== 2'b00) begin errors++; $display("FAIL fullpop_empty: busy/wr got %b want 00", {o_busy, o_wr}); end
    i_rdAddr1 = 0;
  endtask

  task automatic test_mid_reset;
    int seen;
    seen = 0;
    tick(); drive(1, 1, 32'h1, 1, 12, 32'hC0);
    tick(); drive(1, 1, 32'h1, 1, 13, 32'hD0);
    tick(); drive(1, 1, 32'h1, 0, 0, 0);
    tick(); tick(); tick();
    #4;
    checks++;
    if ({o_stallReq, o_busy} !== 2'b11) begin
      errors++; $display("FAIL midrst_pre: stall/busy got %b want 11", {o_stallReq, o_busy});
    end
    i_reset = 0;
    tick();
    i_reset = 1; drive(0, 0, 0, 0, 0, 0); i_rdAddr1 = 12; i_rdAddr2 = 13;
    #4;
    checks++;
    if ({o_busy, o_stallReq, o_hazard, o_bReady} !== 4'b0001) begin
      errors++; $display("FAIL midrst_post: busy/stall/haz/ready got %b want 0001",
                         {o_busy, o_stallReq, o_hazard, o_bReady});
    end
    for (int c = 0; c < 4; c++) begin
      if (o_wr) seen++;
      tick(); #4;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_nowrite: %0d stale writes seen want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_starvation();
    test_x0();
    test_full_pop();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
